// File: rtl/tone_pkg.sv
// Shared constants and helpers for the multi-channel tone divider.
// Note half-periods assume a 50 MHz system clock.
package tone_pkg;

   localparam int unsigned DEFAULT_HALF = 1562;

   // Song-table half-periods: f_clk / (2 * f_note)
   localparam int unsigned NOTE_C4_HALF = 95556;
   localparam int unsigned NOTE_E4_HALF = 75843;
   localparam int unsigned NOTE_G4_HALF = 63776;
   localparam int unsigned NOTE_A4_HALF = 56818;
   localparam int unsigned NOTE_C5_HALF = 47778;

   function automatic int unsigned ch_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tone_div_ch.sv
// One divider channel: square wave at f_clk/(2*half) plus a tick on each rising edge.
// Half-period updates are held pending and land only at a toggle or while stopped.
module tone_div_ch
   import tone_pkg::*;
#(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned DEFAULT_HALF = tone_pkg::DEFAULT_HALF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] wr_half_i,
   output logic             wave_o,
   output logic             tick_o,
   output logic             pend_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             pend_q, pend_d;
   logic             wave_q, wave_d;
   logic             tick_q, tick_d;
   logic             running;
   logic             wrap;

   always_comb begin
      running   = en_i && (half_q != '0);
      // half_q - 1 cannot wrap here because running implies half_q != 0
      wrap      = running && (cnt_q == (half_q - CNT_W'(1)));
      cnt_d     = cnt_q;
      half_d    = half_q;
      pending_d = pending_q;
      pend_d    = pend_q;
      wave_d    = wave_q;
      tick_d    = 1'b0;

      if (running) begin
         if (wrap) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
            tick_d = ~wave_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d  = '0;
         wave_d = 1'b0;
      end

      if (pend_q && (wrap || !running)) begin
         half_d = pending_q;
         pend_d = 1'b0;
      end

      // A write landing on a toggle stays pending for the next boundary
      if (wr_i) begin
         pending_d = wr_half_i;
         pend_d    = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         half_q    <= CNT_W'(DEFAULT_HALF);
         pending_q <= '0;
         pend_q    <= 1'b0;
         wave_q    <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         pending_q <= pending_d;
         pend_q    <= pend_d;
         wave_q    <= wave_d;
         tick_q    <= tick_d;
      end
   end

   assign wave_o = wave_q;
   assign tick_o = tick_q;
   assign pend_o = pend_q;

endmodule

// File: rtl/tone_divider_multi.sv
// Multi-channel programmable tone divider: decodes the shared write bus into
// per-channel strobes and instantiates one tone_div_ch per channel.
module tone_divider_multi
   import tone_pkg::*;
#(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned CH_W         = ch_width(NUM_CH),
   parameter int unsigned DEFAULT_HALF = tone_pkg::DEFAULT_HALF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NUM_CH-1:0] ch_en_i,
   input  logic              wr_en_i,
   input  logic [CH_W-1:0]   wr_ch_i,
   input  logic [CNT_W-1:0]  wr_half_i,
   output logic [NUM_CH-1:0] wave_o,
   output logic [NUM_CH-1:0] tick_o,
   output logic [NUM_CH-1:0] pend_o
);

   logic [NUM_CH-1:0] wr_sel;

   // Selects at or above NUM_CH match no channel and are dropped
   always_comb begin
      wr_sel = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (wr_en_i && (wr_ch_i == CH_W'(i))) begin
            wr_sel[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tone_div_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_HALF(DEFAULT_HALF)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .en_i     (ch_en_i[g]),
         .wr_i     (wr_sel[g]),
         .wr_half_i(wr_half_i),
         .wave_o   (wave_o[g]),
         .tick_o   (tick_o[g]),
         .pend_o   (pend_o[g])
      );
   end

endmodule

// File: tb/tb_tone_divider_multi.sv
// Self-checking bench for tone_divider_multi: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_tone_divider_multi;

   localparam int NCH = 4;
   localparam int CW  = 16;
   localparam int CHW = 3;
   localparam int DEF = 1562;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] ch_en = '0;
   logic           wr_en = 1'b0;
   logic [CHW-1:0] wr_ch = '0;
   logic [CW-1:0]  wr_half = '0;
   logic [NCH-1:0] wave, tick, pend;

   int checks = 0;
   int errors = 0;

   // Model state: half-period, cycles elapsed in current half-period, pending value
   int             m_half[NCH];
   int             m_elapsed[NCH];
   int             m_pval[NCH];
   logic [NCH-1:0] m_wave = '0;
   logic [NCH-1:0] m_tick = '0;
   logic [NCH-1:0] m_pend = '0;

   tone_divider_multi #(
      .NUM_CH      (NCH),
      .CNT_W       (CW),
      .CH_W        (CHW),
      .DEFAULT_HALF(DEF)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .ch_en_i  (ch_en),
      .wr_en_i  (wr_en),
      .wr_ch_i  (wr_ch),
      .wr_half_i(wr_half),
      .wave_o   (wave),
      .tick_o   (tick),
      .pend_o   (pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Next state of every channel from the current inputs, by the behavioural rules
   task automatic model_step();
      for (int i = 0; i < NCH; i++) begin
         if (!rst_n) begin
            m_half[i] = DEF; m_elapsed[i] = 0; m_pval[i] = 0;
            m_wave[i] = 0; m_tick[i] = 0; m_pend[i] = 0;
         end else begin
            bit run, boundary, wr;
            run      = ch_en[i] && (m_half[i] != 0);
            boundary = run && (m_elapsed[i] + 1 == m_half[i]);
            wr       = wr_en && (int'(wr_ch) == i);
            m_tick[i] = 0;
            if (!run) begin
               m_elapsed[i] = 0; m_wave[i] = 0;
            end else if (boundary) begin
               m_elapsed[i] = 0;
               m_wave[i]    = !m_wave[i];
               m_tick[i]    = m_wave[i];
            end else begin
               m_elapsed[i]++;
            end
            if (m_pend[i] && (boundary || !run)) begin
               m_half[i] = m_pval[i]; m_pend[i] = 0;
            end
            if (wr) begin
               m_pval[i] = int'(wr_half); m_pend[i] = 1;
            end
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("wave", int'(wave), int'(m_wave));
      chk("tick", int'(tick), int'(m_tick));
      chk("pend", int'(pend), int'(m_pend));
   endtask

   task automatic write(input int ch, input int h);
      wr_en = 1'b1; wr_ch = CHW'(ch); wr_half = CW'(h);
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic run_until_rise(input int ch, input int limit, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!(wave[ch] && tick[ch]) && n < limit);
   endtask

   task automatic run_until_fall(input int ch, input int limit, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (wave[ch] && n < limit);
   endtask

   initial begin
      int n;
      int cnt_tick, cnt_high;

      // Reset state
      rst_n = 1'b0;
      wr_en = 1'b1; wr_ch = 3'd2; wr_half = 16'd7;
      repeat (3) cycle();
      wr_en = 1'b0;
      chk("reset_wave", int'(wave), 0);
      chk("reset_tick", int'(tick), 0);
      chk("reset_pend", int'(pend), 0);

      // Default half-period on channel 0
      rst_n = 1'b1;
      ch_en = 4'b0001;
      run_until_rise(0, 4000, n);
      chk("first_rise_default", n, 1562);
      run_until_rise(0, 8000, n);
      chk("period_default", n, 3124);
      chk("other_ch_idle", int'(wave[3:1]), 0);

      // Half 4, then write 2 at cnt=1: remainder of half-period stays 4
      ch_en[0] = 1'b0;
      write(0, 4);
      cycle();
      chk("stopped_apply_pend", int'(pend[0]), 0);
      ch_en[0] = 1'b1;
      run_until_rise(0, 20, n);
      chk("rise_half4", n, 4);
      cycle();
      write(0, 2);
      chk("pend_after_write", int'(pend[0]), 1);
      run_until_fall(0, 20, n);
      chk("old_half_remainder", n, 2);
      chk("pend_clears_at_toggle", int'(pend[0]), 0);
      run_until_rise(0, 20, n);
      chk("new_half2", n, 2);

      // Back-to-back writes on a stopped channel; last one wins
      write(1, 3);
      chk("pend1_first", int'(pend[1]), 1);
      write(1, 5);
      chk("pend1_second", int'(pend[1]), 1);
      cycle();
      chk("pend1_applied", int'(pend[1]), 0);
      write(7, 9);
      chk("out_of_range_ignored", int'(pend), 0);
      ch_en[1] = 1'b1;
      run_until_rise(1, 20, n);
      chk("rise_half5", n, 5);

      // Half 0 silences a running channel
      write(1, 0);
      repeat (15) cycle();
      cnt_high = 0; cnt_tick = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         cnt_high += int'(wave[1]);
         cnt_tick += int'(tick[1]);
      end
      chk("silent_wave", cnt_high, 0);
      chk("silent_tick", cnt_tick, 0);
      write(1, 6);
      cycle();
      chk("stopped_apply_latency", int'(pend[1]), 0);
      run_until_rise(1, 20, n);
      chk("rise_half6", n, 6);

      // Half 1: toggles every cycle, tick every second cycle
      write(2, 1);
      cycle();
      ch_en[2] = 1'b1;
      cnt_high = 0; cnt_tick = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         cnt_high += int'(wave[2]);
         cnt_tick += int'(tick[2]);
      end
      chk("half1_high", cnt_high, 5);
      chk("half1_ticks", cnt_tick, 5);
      if (!wave[2]) cycle();
      ch_en[2] = 1'b0;
      cycle();
      chk("disable_mid_high", int'(wave[2]), 0);

      // Reset mid-period discards pending value and restores default half
      write(0, 9);
      chk("pend_before_reset", int'(pend[0]), 1);
      rst_n = 1'b0;
      ch_en = 4'b0001;
      cycle();
      chk("midreset_wave", int'(wave), 0);
      chk("midreset_pend", int'(pend), 0);
      rst_n = 1'b1;
      run_until_rise(0, 4000, n);
      chk("rise_after_reset", n, 1562);

      // Randomized traffic against the model
      for (int k = 0; k < 4000; k++) begin
         rst_n = ($urandom_range(0, 599) != 0);
         if ($urandom_range(0, 15) == 0) ch_en = NCH'($urandom);
         wr_en   = ($urandom_range(0, 5) == 0);
         wr_ch   = CHW'($urandom_range(0, 7));
         wr_half = ($urandom_range(0, 9) == 0) ? CW'(0) : CW'($urandom_range(1, 12));
         cycle();
      end
      wr_en = 1'b0;
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tone_divider_multi.md
Name: tone_divider_multi

Overview:
- Multi-channel, runtime-programmable clock/tone divider. Successor to the fixed single-output divider.
- Each channel generates a 50%-duty square wave at f_clk/(2*half) and a one-cycle period tick.
- The song sequencer programs each channel's half-period through a write port. Updates are applied glitch-free at the channel's next toggle boundary.
- Outputs drive the audio pin mux and the note-timing logic.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 16, width of half-period and counter registers.
- CH_W, 2, width of the channel select; must satisfy 2**CH_W >= NUM_CH.
- DEFAULT_HALF, 1562, half-period loaded into every channel at reset.

Ports:
- clk, in, 1, system clock; all logic on its rising edge.
- rst_n, in, 1, synchronous active-low reset, sampled on posedge clk.
- ch_en, in, NUM_CH, per-channel run enable (level).
- wr_en, in, 1, write strobe for a half-period update (one cycle = one write).
- wr_ch, in, CH_W, target channel of the write.
- wr_half, in, CNT_W, new half-period in clk cycles; 0 = silence.
- wave, out, NUM_CH, square-wave outputs.
- tick, out, NUM_CH, one-cycle pulse per full period, asserted with each wave 0->1 edge.
- pend, out, NUM_CH, high while a written value awaits its boundary.

Behaviour:
- Reset (rst_n=0 at posedge), per channel:
  - half=DEFAULT_HALF, cnt=0, wave=0, tick=0, pend=0, pending value=0.
  - A write in the reset cycle is dropped.
- Running condition: ch_en[i]=1 and half!=0. While running, each cycle:
  - If cnt==half-1: cnt<=0, wave toggles, tick<=1 if the new wave is 1 (else 0).
  - Otherwise: cnt<=cnt+1, tick<=0.
- Output period: 2*half clk cycles, duty exactly 50%. half=1 gives f_clk/2, toggling every cycle, with tick every 2nd cycle.
- Stopped (ch_en[i]=0 or half==0): cnt<=0, wave<=0, tick<=0 on the next edge. Re-enabling starts a fresh period; the first toggle (0->1, with tick) occurs half cycles after ch_en rises.
- Write, wr_en=1 with wr_ch<NUM_CH: pending[wr_ch]<=wr_half and pend[wr_ch]<=1.
- Write with wr_ch>=NUM_CH: ignored entirely.
- A second write before apply overwrites pending. Last write wins, pend stays 1.
- Apply: the pending value is copied into half, and pend clears, on whichever comes first:
  - (a) a toggle edge (the same cycle cnt wraps); the new half governs the following half-period;
  - (b) any cycle the channel is stopped; applied on the next edge, latency 1.
- Write and toggle in the same cycle: the write's value is not applied at that toggle. It becomes pending and applies at the next toggle. This avoids a one-cycle race.
- Applying half=0 stops the channel. wave is forced to 0 on the next edge even if it was mid-high.
- The counter never exceeds half-1. If half shrinks while cnt>=new half, that cannot occur because updates land only at cnt=0.
- Arithmetic: unsigned CNT_W. Comparison uses half-1 without wrap, since it is only evaluated when half!=0.
- tick and wave are registered outputs. No combinational path from inputs to outputs.
- Channels are fully independent and share only the write bus.

Decomposition:
- Shared package tone_pkg:
  - DEFAULT_HALF
  - note half-period constants for the song table (e.g. A4 at 50 MHz = 56818)
  - CH_W helper function (clog2)
- One sub-module, tone_div_ch: single channel holding cnt, half, pending, pend, wave and tick.
  - Instantiated NUM_CH times via generate.
  - Top level only decodes wr_ch into per-channel write strobes.

Test Plan:
- Reset then ch_en=0001, no writes -> wave[0] first rises 1562 cycles after enable, period 3124, tick every 3124 cycles. Channels 1..3 stay 0.
- Channel 0 running with half=4; write wr_ch=0, wr_half=2 at cnt=1 -> pend[0]=1 until the next wrap. Remaining half-period is 4 cycles, then half-periods of 2; pend clears at that toggle.
- Write half=3 then half=5 on consecutive cycles to channel 1 -> only 5 applies, pend[1] stays 1 throughout. Write wr_ch=7 with NUM_CH=4 -> no state change.
- Write half=0 to a running channel -> at the next toggle wave=0 and stays 0, tick=0. Write half=6 -> since the channel is stopped, it applies after 1 cycle; the first rise occurs 6 cycles later.
- half=1, ch_en=1 -> wave toggles every cycle, tick on every 0->1 edge. Drop ch_en mid-high -> wave=0 and cnt=0 on the next edge.
- Assert rst_n=0 mid-period with pend=1 -> all outputs are 0 on the next edge, half=1562, and the pending value is discarded.
